conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 SHALL have parameter IC_NUM, default 64, input channels per layer.
REQ-002 SHALL have parameter OC_NUM, default 64, output channels per layer.
REQ-003 SHALL have parameter COL_NUM, default 56, feature-map columns per channel.
REQ-004 SHALL have parameter WHT_NUM, default 10, weights per (oc,ic) pair: 9 for 3x3, 1 for 1x1.
REQ-005 SHALL use one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports:
- start input 1, layer start request.
- abort input 1, synchronous cancel.
- wht_valid input 1 / wht_ready output 1, weight stream handshake.
- fmap_valid input 1 / fmap_ready output 1, feature-column handshake.
- out_ready input 1 / out_valid output 1, result-column handshake.
- wht_ld output 1, weight register load strobe.
- wht_idx output clog2(WHT_NUM), weight slot being loaded.
- pe_en output 1, PE array compute strobe.
- acc_clr output 1, accumulator clear-on-write.
- pad_l, pad_r output 1, zero-padding select for the first and last column.
- col_idx output clog2(COL_NUM), current column.
- ic_idx output clog2(IC_NUM), current input channel.
- oc_idx output clog2(OC_NUM), current output channel.
- busy output 1, state is not IDLE.
- done output 1, layer-complete pulse.

Function
REQ-007 SHALL implement the states IDLE, LOAD_W, RUN, DRAIN and DONE.
REQ-008 In IDLE, start=1 SHALL move the block to LOAD_W on the next cycle and clear all indices; start SHALL be ignored in every other state.
REQ-009 In LOAD_W, wht_ready SHALL be 1 and wht_ld SHALL equal wht_valid.
- Each accepted weight increments wht_idx.
- Acceptance of weight WHT_NUM-1 SHALL reset wht_idx to 0 and move to RUN.
REQ-010 In RUN, fmap_ready SHALL be 1 and pe_en SHALL equal fmap_valid.
- Each accepted column increments col_idx.
- pad_l=pe_en&&(col_idx==0); pad_r=pe_en&&(col_idx==COL_NUM-1).
REQ-011 acc_clr SHALL equal pe_en&&(ic_idx==0), so the first input channel overwrites the accumulator and later channels add to it.
REQ-012 On acceptance of column COL_NUM-1 in RUN, col_idx SHALL wrap to 0.
- If ic_idx<IC_NUM-1: ic_idx increments and the state goes to LOAD_W.
- Otherwise the state goes to DRAIN.
REQ-013 In DRAIN, out_valid SHALL be 1 with col_idx naming the output column.
- Each out_valid&&out_ready advances col_idx.
- out_valid SHALL hold and col_idx SHALL be stable while out_ready=0.
REQ-014 On the last drained column, col_idx SHALL wrap to 0 and ic_idx SHALL become 0.
- If oc_idx<OC_NUM-1: oc_idx increments and the state goes to LOAD_W.
- Otherwise the state goes to DONE.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 A handshake output (wht_ready, fmap_ready, out_valid) SHALL be 0 in every state other than its own; strobes (wht_ld, pe_en, acc_clr, pad_l, pad_r) SHALL be combinational and never assert outside their state.
REQ-017 With all valid/ready inputs held high, the minimum per-layer latency from start sampled to done SHALL be OC_NUM*(IC_NUM*(WHT_NUM+COL_NUM)+COL_NUM)+1 cycles.
REQ-018 abort=1 SHALL move any state to IDLE on the next cycle and clear all indices; done SHALL NOT pulse; abort SHALL take priority over start and all handshakes in the same cycle.
REQ-019 Index counters SHALL never exceed their parameter minus 1, and wrap-around SHALL occur only at the transitions above.

Reset
REQ-020 rst_n=0 SHALL immediately force state IDLE, all indices 0, and busy, done, wht_ready, fmap_ready, out_valid and all strobes to 0, regardless of state, including mid-layer.
REQ-021 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification (IC_NUM=2, OC_NUM=2, COL_NUM=4, WHT_NUM=10)
REQ-022 start pulse, all valids/readys high -> 10 wht_ld, 4 pe_en, 10 wht_ld, 4 pe_en, 4 out beats, repeated twice; done exactly 65 cycles after start; busy high for 64 cycles.
REQ-023 fmap_valid toggled 0/1 each cycle in RUN -> pe_en only on valid cycles; pad_l on column 0 and pad_r on column 3 only; acc_clr only while ic_idx=0.
REQ-024 out_ready held 0 for 5 cycles at DRAIN column 2 -> out_valid stays 1 and col_idx stays 2; resumes on release; total latency +5.
REQ-025 abort asserted at oc_idx=1, RUN column 1 -> IDLE next cycle; all indices 0; no done; a new start then completes a normal 65-cycle layer.
REQ-026 rst_n pulled low mid-LOAD_W (wht_idx=6) -> all outputs 0 asynchronously; start asserted during DRAIN -> ignored, oc_idx unchanged.

Source files
------------

// File: rtl/conv_sched.sv
// conv_sched: sequencing controller for a convolution layer.
// For each output channel it loops over the input channels. Each input
// channel loads its weight set and then streams every feature-map column
// through the PE array. After the last input channel, the accumulated
// output columns are drained. The block pulses done once per layer.
module conv_sched #(
    parameter int IC_NUM  = 64,
    parameter int OC_NUM  = 64,
    parameter int COL_NUM = 56,
    parameter int WHT_NUM = 10,
    localparam int WW = (WHT_NUM > 1) ? $clog2(WHT_NUM) : 1,
    localparam int CW = (COL_NUM > 1) ? $clog2(COL_NUM) : 1,
    localparam int IW = (IC_NUM  > 1) ? $clog2(IC_NUM)  : 1,
    localparam int OW = (OC_NUM  > 1) ? $clog2(OC_NUM)  : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          wht_valid,
    output logic          wht_ready,
    input  logic          fmap_valid,
    output logic          fmap_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic          wht_ld,
    output logic [WW-1:0] wht_idx,
    output logic          pe_en,
    output logic          acc_clr,
    output logic          pad_l,
    output logic          pad_r,
    output logic [CW-1:0] col_idx,
    output logic [IW-1:0] ic_idx,
    output logic [OW-1:0] oc_idx,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Terminal values of each counter, sized to match the counter width.
    localparam logic [WW-1:0] WHT_LAST = WW'(WHT_NUM - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COL_NUM - 1);
    localparam logic [IW-1:0] IC_LAST  = IW'(IC_NUM - 1);
    localparam logic [OW-1:0] OC_LAST  = OW'(OC_NUM - 1);

    state_t        state_q, state_d;
    logic [WW-1:0] wht_idx_q, wht_idx_d;
    logic [CW-1:0] col_idx_q, col_idx_d;
    logic [IW-1:0] ic_idx_q,  ic_idx_d;
    logic [OW-1:0] oc_idx_q,  oc_idx_d;

    // State and index registers. Reset returns the block to IDLE with all indices cleared.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its sources, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wht_idx_q <= '0;
            col_idx_q <= '0;
            ic_idx_q  <= '0;
            oc_idx_q  <= '0;
        end else begin
            state_q   <= state_d;
            wht_idx_q <= wht_idx_d;
            col_idx_q <= col_idx_d;
            ic_idx_q  <= ic_idx_d;
            oc_idx_q  <= oc_idx_d;
        end
    end

    // Next-state, index update, handshake and strobe decode. Abort overrides everything.
    // NOTE: every signal written here gets a default first. Without that, a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        wht_idx_d  = wht_idx_q;
        col_idx_d  = col_idx_q;
        ic_idx_d   = ic_idx_q;
        oc_idx_d   = oc_idx_q;
        wht_ready  = 1'b0;
        wht_ld     = 1'b0;
        fmap_ready = 1'b0;
        pe_en      = 1'b0;
        acc_clr    = 1'b0;
        pad_l      = 1'b0;
        pad_r      = 1'b0;
        out_valid  = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_W;
                    wht_idx_d = '0;
                    col_idx_d = '0;
                    ic_idx_d  = '0;
                    oc_idx_d  = '0;
                end
            end

            LOAD_W: begin
                wht_ready = 1'b1;
                wht_ld    = wht_valid;
                if (wht_valid) begin
                    if (wht_idx_q == WHT_LAST) begin
                        wht_idx_d = '0;
                        state_d   = RUN;
                    end else begin
                        wht_idx_d = wht_idx_q + 1'b1;
                    end
                end
            end

            RUN: begin
                fmap_ready = 1'b1;
                pe_en      = fmap_valid;
                // The first input channel overwrites the accumulator; later channels add to it.
                acc_clr    = fmap_valid && (ic_idx_q == '0);
                pad_l      = fmap_valid && (col_idx_q == '0);
                pad_r      = fmap_valid && (col_idx_q == COL_LAST);
                if (fmap_valid) begin
                    if (col_idx_q == COL_LAST) begin
                        col_idx_d = '0;
                        if (ic_idx_q != IC_LAST) begin
                            ic_idx_d = ic_idx_q + 1'b1;
                            state_d  = LOAD_W;
                        end else begin
                            state_d  = DRAIN;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (col_idx_q == COL_LAST) begin
                        col_idx_d = '0;
                        ic_idx_d  = '0;
                        if (oc_idx_q != OC_LAST) begin
                            oc_idx_d = oc_idx_q + 1'b1;
                            state_d  = LOAD_W;
                        end else begin
                            state_d  = DONE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 1'b1;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            state_d   = IDLE;
            wht_idx_d = '0;
            col_idx_d = '0;
            ic_idx_d  = '0;
            oc_idx_d  = '0;
        end
    end

    // Indices are exposed straight from the registers.
    assign wht_idx = wht_idx_q;
    assign col_idx = col_idx_q;
    assign ic_idx  = ic_idx_q;
    assign oc_idx  = oc_idx_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_conv_sched.sv
// Self-checking bench for conv_sched. A reference model walks a flat list of
// layer phases (load, run, drain, done). Every cycle it predicts the full
// output vector, and the bench compares that prediction with the DUT.
module tb_conv_sched;

    localparam int IC  = 2;
    localparam int OC  = 2;
    localparam int COL = 4;
    localparam int WHT = 10;
    localparam int WW  = $clog2(WHT);
    localparam int CW  = $clog2(COL);
    localparam int IW  = $clog2(IC);
    localparam int OW  = $clog2(OC);
    localparam int PADW = 32 - 10 - WW - CW - IW - OW;
    localparam int NPH = OC * (2 * IC + 1) + 1;

    logic          clk;
    logic          rst_n;
    logic          start, abort, wht_valid, fmap_valid, out_ready;
    logic          wht_ready, fmap_ready, out_valid, wht_ld, pe_en, acc_clr;
    logic          pad_l, pad_r, busy, done;
    logic [WW-1:0] wht_idx;
    logic [CW-1:0] col_idx;
    logic [IW-1:0] ic_idx;
    logic [OW-1:0] oc_idx;

    conv_sched #(
        .IC_NUM(IC), .OC_NUM(OC), .COL_NUM(COL), .WHT_NUM(WHT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .wht_valid(wht_valid), .wht_ready(wht_ready),
        .fmap_valid(fmap_valid), .fmap_ready(fmap_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .wht_ld(wht_ld), .wht_idx(wht_idx), .pe_en(pe_en), .acc_clr(acc_clr),
        .pad_l(pad_l), .pad_r(pad_r), .col_idx(col_idx), .ic_idx(ic_idx),
        .oc_idx(oc_idx), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dut_vec;
    assign dut_vec = {{PADW{1'b0}}, busy, done, wht_ready, wht_ld, fmap_ready, pe_en,
                      acc_clr, pad_l, pad_r, out_valid, wht_idx, col_idx, ic_idx, oc_idx};

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {K_LOAD, K_RUN, K_DRAIN, K_DONE} kind_t;
    typedef struct {
        kind_t kind;
        int    ic;
        int    oc;
        int    len;
    } phase_t;

    phase_t ph[NPH];
    bit     m_active  = 1'b0;
    int     m_pos     = 0;
    int     m_beat    = 0;
    int     m_idle_oc = 0;

    function automatic void build_phases();
        int n = 0;
        for (int o = 0; o < OC; o++) begin
            for (int i = 0; i < IC; i++) begin
                ph[n] = '{K_LOAD, i, o, WHT}; n++;
                ph[n] = '{K_RUN,  i, o, COL}; n++;
            end
            ph[n] = '{K_DRAIN, IC - 1, o, COL}; n++;
        end
        ph[n] = '{K_DONE, 0, OC - 1, 1};
    endfunction

    function automatic logic [31:0] model_out();
        logic b = 0, dn = 0, wr = 0, ld = 0, fr = 0, pe = 0, ac = 0, pl = 0, pr = 0, ov = 0;
        int wi = 0, ci = 0, ii = 0, oi = m_idle_oc;
        if (m_active) begin
            b  = 1;
            ii = ph[m_pos].ic;
            oi = ph[m_pos].oc;
            case (ph[m_pos].kind)
                K_LOAD: begin wr = 1; ld = wht_valid; wi = m_beat; end
                K_RUN: begin
                    fr = 1;
                    pe = fmap_valid;
                    ci = m_beat;
                    ac = pe && (ii == 0);
                    pl = pe && (m_beat == 0);
                    pr = pe && (m_beat == COL - 1);
                end
                K_DRAIN: begin ov = 1; ci = m_beat; end
                default: dn = 1;
            endcase
        end
        return {{PADW{1'b0}}, b, dn, wr, ld, fr, pe, ac, pl, pr, ov,
                wi[WW-1:0], ci[CW-1:0], ii[IW-1:0], oi[OW-1:0]};
    endfunction

    function automatic void model_step();
        bit adv;
        if (abort) begin
            m_active  = 0;
            m_idle_oc = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_pos    = 0;
                m_beat   = 0;
            end
        end else begin
            case (ph[m_pos].kind)
                K_LOAD:  adv = wht_valid;
                K_RUN:   adv = fmap_valid;
                K_DRAIN: adv = out_ready;
                default: adv = 1;
            endcase
            if (adv) begin
                m_beat++;
                if (m_beat == ph[m_pos].len) begin
                    m_beat = 0;
                    m_pos++;
                    if (m_pos == NPH) begin
                        m_active  = 0;
                        m_idle_oc = OC - 1;
                    end
                end
            end
        end
    endfunction

    function automatic bit in_phase(input kind_t k, input int oc, input int beat);
        return m_active && (ph[m_pos].kind == k) && (ph[m_pos].oc == oc) && (m_beat == beat);
    endfunction

    // ---------------- stimulus ----------------
    int cnt_ld, cnt_pe, cnt_out, cnt_busy, cnt_done;
    bit done_now;

    task automatic clear_stats();
        cnt_ld = 0; cnt_pe = 0; cnt_out = 0; cnt_busy = 0; cnt_done = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, then advance the model.
    task automatic step(input logic s, input logic a, input logic wv, input logic fv, input logic orr);
        @(negedge clk);
        start = s; abort = a; wht_valid = wv; fmap_valid = fv; out_ready = orr;
        #1;
        check("cycle", dut_vec, model_out());
        cnt_ld   += int'(wht_ld);
        cnt_pe   += int'(pe_en);
        cnt_out  += int'(out_valid && out_ready);
        cnt_busy += int'(busy && !done);
        cnt_done += int'(done);
        done_now  = done;
        @(posedge clk);
        model_step();
    endtask

    // mode 0: all high; 1: fmap_valid toggles; 2: 5-cycle drain stall plus start during drain; 3: random
    task automatic run_layer(input int mode, output int lat);
        int stall_cnt = 0;
        logic wv, fv, orr, s;
        lat = -1;
        clear_stats();
        step(1, 0, 1, 1, 1);
        for (int k = 1; k <= 600; k++) begin
            s = 0; wv = 1; fv = 1; orr = 1;
            if (mode == 1) fv = k[0];
            if (mode == 2) begin
                if (m_active && ph[m_pos].kind == K_DRAIN) s = 1;
                if (stall_cnt < 5 && in_phase(K_DRAIN, 0, 2)) begin
                    orr = 0;
                    stall_cnt++;
                end
            end
            if (mode == 3) begin
                s   = ($urandom_range(0, 3) == 0);
                wv  = ($urandom_range(0, 3) != 0);
                fv  = ($urandom_range(0, 3) != 0);
                orr = ($urandom_range(0, 3) != 0);
            end
            step(s, 0, wv, fv, orr);
            if (done_now) begin
                lat = k;
                break;
            end
        end
    endtask

    int lat;
    bit reached;

    initial begin
        build_phases();
        rst_n = 1'b0;
        start = 0; abort = 0; wht_valid = 0; fmap_valid = 0; out_ready = 0;
        #3;
        check("reset_outputs", dut_vec, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1);

        // Full-rate layer
        run_layer(0, lat);
        check("full_latency", lat, 65);
        check("full_wht_ld", cnt_ld, 40);
        check("full_pe_en", cnt_pe, 16);
        check("full_out_beats", cnt_out, 8);
        check("full_busy_cycles", cnt_busy, 64);
        check("full_done_pulses", cnt_done, 1);

        // fmap_valid toggling
        run_layer(1, lat);
        check("toggle_pe_en", cnt_pe, 16);
        check("toggle_done_pulses", cnt_done, 1);

        // Drain stall with start held during DRAIN
        run_layer(2, lat);
        check("stall_latency", lat, 70);
        check("stall_out_beats", cnt_out, 8);

        // Abort at oc 1, RUN column 1 (start and handshakes also high)
        clear_stats();
        step(1, 0, 1, 1, 1);
        reached = 0;
        for (int k = 0; k < 200; k++) begin
            if (in_phase(K_RUN, 1, 1)) begin reached = 1; break; end
            step(0, 0, 1, 1, 1);
        end
        check("abort_reached", reached, 1);
        step(1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1);
        check("abort_idle", {busy, done, wht_idx, col_idx, ic_idx, oc_idx}, 0);
        check("abort_no_done", cnt_done, 0);
        run_layer(0, lat);
        check("after_abort_latency", lat, 65);

        // Randomised layers
        for (int r = 0; r < 4; r++) begin
            run_layer(3, lat);
            check("rnd_done_seen", lat > 0, 1);
            check("rnd_wht_ld", cnt_ld, 40);
            check("rnd_pe_en", cnt_pe, 16);
            check("rnd_out_beats", cnt_out, 8);
        end

        // Free-running random start/abort traffic
        for (int k = 0; k < 400; k++)
            step($urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0);
        step(0, 1, 0, 0, 0);

        // Asynchronous reset in LOAD_W with wht_idx = 6
        step(1, 0, 1, 1, 1);
        reached = 0;
        for (int k = 0; k < 50; k++) begin
            if (in_phase(K_LOAD, 0, 6)) begin reached = 1; break; end
            step(0, 0, 1, 1, 1);
        end
        check("rst_reached", reached, 1);
        @(negedge clk);
        #1;
        check("pre_rst_widx", wht_idx, 6);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs", dut_vec, 32'h0);
        m_active  = 0;
        m_idle_oc = 0;
        @(negedge clk);
        check("rst_held_outputs", dut_vec, 32'h0);
        rst_n = 1'b1;
        clear_stats();
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 1);
        check("post_rst_idle_busy", cnt_busy, 0);
        run_layer(0, lat);
        check("post_rst_latency", lat, 65);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
